// File: rtl/dec_scan_ctrl.sv
// Scan controller for a downstream dec2to4: walks the masked channels, holds each
// one for a programmable dwell and leaves a blanking gap (en low) between channels.
module dec_scan_ctrl #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       mask,
    input  logic [DIV_W-1:0] div,
    output logic [1:0]       a,
    output logic             en,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } state_e;

    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    state_e           state_q, state_d;
    logic [1:0]       a_q, a_d;
    logic             en_q, en_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic             select;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                r     = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Searches cur+1, cur+2, cur+3 and finally cur itself (modulo 4).
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (m[idx] && !found) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        en_d    = en_q;
        wrap_d  = 1'b0;
        busy_d  = busy_q;
        blank_d = blank_q;
        dwell_d = dwell_q;
        select  = 1'b0;

        if (!run) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            blank_d = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mask != '0) begin
                        a_d    = lowest_set(mask);
                        select = 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_q == '0) begin
                        state_d = ACTIVE;
                        en_d    = 1'b1;
                        dwell_d = div;
                    end else begin
                        blank_d = blank_q - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (dwell_q == '0) begin
                        if (mask == '0) begin
                            state_d = IDLE;
                            en_d    = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            a_d    = next_set(mask, a_q);
                            wrap_d = (next_set(mask, a_q) <= a_q);
                            select = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase

            // A selection enters the blanking gap, or skips straight to the dwell when there is none.
            if (select) begin
                busy_d = 1'b1;
                if (BLANK_CYC == 0) begin
                    state_d = ACTIVE;
                    en_d    = 1'b1;
                    dwell_d = div;
                end else begin
                    state_d = BLANK;
                    en_d    = 1'b0;
                    blank_d = BLANK_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            blank_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            en_q    <= en_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            blank_q <= blank_d;
            dwell_q <= dwell_d;
        end
    end

    assign a    = a_q;
    assign en   = en_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for dec_scan_ctrl: per-cycle expected {wrap,en,a} and busy
// tables hand-derived for BLANK_CYC=2.
module tb_dec_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  mask;
    logic [15:0] div;
    logic [1:0]  a;
    logic        en;
    logic        wrap;
    logic        busy;

    int tests;
    int fails;

    dec_scan_ctrl #(
        .DIV_W    (16),
        .BLANK_CYC(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .mask (mask),
        .div  (div),
        .a    (a),
        .en   (en),
        .wrap (wrap),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {wrap, en, a[1:0]} per cycle.
    logic [3:0] seq1 [27] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h5,
                              4'h5, 4'h5, 4'h5, 4'h2, 4'h2, 4'h6, 4'h6, 4'h6, 4'h6,
                              4'h3, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'h8, 4'h0, 4'h4};
    logic [3:0] seq2 [13] = '{4'h1, 4'h1, 4'h5, 4'h3, 4'h3, 4'h7, 4'h9,
                              4'h1, 4'h5, 4'h3, 4'h3, 4'h7, 4'h9};
    logic [3:0] seq3 [9]  = '{4'h2, 4'h2, 4'h6, 4'hA, 4'h2, 4'h6, 4'hA, 4'h2, 4'h6};
    logic [3:0] seq4 [18] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1, 4'h5,
                              4'h5, 4'h2, 4'h2, 4'h6, 4'h6, 4'h6, 4'h6, 4'h2, 4'h2};

    task automatic check(input string tag, input int idx, input logic [3:0] exp_v,
                         input logic exp_busy);
        tests++;
        assert ({wrap, en, a} === exp_v)
        else begin
            fails++;
            $error("FAIL %s[%0d] {wrap,en,a} observed=%h expected=%h", tag, idx,
                   {wrap, en, a}, exp_v);
        end
        tests++;
        assert (busy === exp_busy)
        else begin
            fails++;
            $error("FAIL %s[%0d] busy observed=%b expected=%b", tag, idx, busy, exp_busy);
        end
    endtask

    task automatic cyc(input string tag, input int idx, input logic [3:0] exp_v,
                       input logic exp_busy);
        @(posedge clk);
        @(negedge clk);
        check(tag, idx, exp_v, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        run   = 1'b1;
        mask  = 4'hF;
        div   = 16'd3;

        // Held in reset with run/mask active.
        @(negedge clk);
        check("reset", 0, 4'h0, 1'b0);
        @(negedge clk);
        check("reset", 1, 4'h0, 1'b0);
        rst_n = 1'b1;

        // Full scan 0,1,2,3,0 with 4-cycle dwell and 2-cycle gaps.
        for (int i = 0; i < 27; i++) cyc("scan_f", i, seq1[i], 1'b1);

        run = 1'b0;
        cyc("stop_a0", 0, 4'h0, 1'b0);

        // Alternating channels 1/3 with single-cycle dwell.
        mask = 4'b1010;
        div  = 16'd0;
        run  = 1'b1;
        for (int i = 0; i < 13; i++) cyc("scan_a", i, seq2[i], 1'b1);

        run = 1'b0;
        cyc("stop_a1", 0, 4'h1, 1'b0);

        // Single channel: wrap on every selection.
        mask = 4'b0100;
        run  = 1'b1;
        for (int i = 0; i < 9; i++) cyc("single", i, seq3[i], 1'b1);

        // Stop mid-ACTIVE on channel 2.
        run = 1'b0;
        cyc("stop_a2", 0, 4'h2, 1'b0);
        cyc("idle_hold", 0, 4'h2, 1'b0);

        // Restart at lowest bit; div change and mask clear mid-dwell.
        mask = 4'hF;
        div  = 16'd3;
        run  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cyc("midchg", i, seq4[i], (i < 16) ? 1'b1 : 1'b0);
            if (i == 3)  div  = 16'd1;
            if (i == 10) div  = 16'd3;
            if (i == 13) mask = 4'h0;
        end

        // Asynchronous reset during ACTIVE.
        mask = 4'hF;
        cyc("pre_rst", 0, 4'h0, 1'b1);
        cyc("pre_rst", 1, 4'h0, 1'b1);
        cyc("pre_rst", 2, 4'h4, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
